imem_load_fetch_ctrl: RTL and testbench
=======================================

Name: imem_load_fetch_ctrl

Overview:
- Controller that owns the single-port synchronous instruction memory and shares its one address/write port between two requesters: a host program loader (write stream) and the core fetch unit (reads).
- Sequences a boot flow: idle -> program load -> run. Gates the core through core_run_o.
- Sits between host/testbench load logic and the fetch stage. Drives the memory's addr/wen/instruction inputs and routes its registered output back to fetch.

Parameters:
- addr_width_p, 10, instruction memory address width; depth = 2**addr_width_p words.

Ports:
- clk  in  1  system clock, all state on posedge
- reset_n_i  in  1  asynchronous active-low reset
- load_start_i  in  1  pulse: begin a program load at load_base_i
- load_base_i  in  addr_width_p  first write address of the load
- load_valid_i  in  1  load_instr_i holds a valid word
- load_instr_i  in  instruction_s  word to write
- load_last_i  in  1  qualifies the final word of the load
- load_ready_o  out  1  controller accepts the load word this cycle
- load_err_o  out  1  sticky: load overflowed memory depth
- core_run_o  out  1  core may fetch/execute
- fetch_req_i  in  1  fetch read request
- fetch_addr_i  in  addr_width_p  fetch address
- fetch_gnt_o  out  1  fetch request accepted this cycle
- fetch_rvalid_o  out  1  fetch_instr_o valid (one cycle after grant)
- fetch_instr_o  out  instruction_s  fetched instruction
- mem_addr_o  out  addr_width_p  to memory addr_i
- mem_wen_o  out  1  to memory wen_i
- mem_instr_o  out  instruction_s  to memory instruction_i
- mem_instr_i  in  instruction_s  from memory instruction_o

Behaviour:
- Reset (asynchronous, reset_n_i=0): state=S_IDLE; load_ready_o=0, load_err_o=0, core_run_o=0, fetch_gnt_o=0, fetch_rvalid_o=0, mem_wen_o=0; word count=0; write pointer=0.
- States: S_IDLE, S_LOAD, S_RUN.
- S_IDLE: nothing granted. load_start_i -> latch load_base_i into the write pointer, clear count and load_err_o, go to S_LOAD.
- S_LOAD:
  - load_ready_o=1 while count < 2**addr_width_p.
  - A word is accepted on load_valid_i&&load_ready_o: mem_wen_o=1, mem_addr_o=write pointer, mem_instr_o=load_instr_i (combinational). Write pointer increments modulo depth, so writes wrap past the top address. count increments; count is addr_width_p+1 bits.
  - Accepted word with load_last_i=1 -> S_RUN next cycle.
  - count reaching depth without a last -> load_ready_o=0, load_err_o=1, go to S_IDLE.
  - fetch_gnt_o=0 and core_run_o=0 throughout.
- S_RUN:
  - core_run_o=1.
  - fetch_gnt_o=fetch_req_i (combinational); mem_addr_o=fetch_addr_i; mem_wen_o=0.
  - fetch_rvalid_o is a registered copy of fetch_gnt_o, so it rises exactly 1 cycle after grant. fetch_instr_o=mem_instr_i, passed straight through because the memory output is already registered.
  - Back-to-back grants give one word per cycle.
- load_start_i in S_RUN:
  - Same cycle: core_run_o drops and no new grant is issued; fetch_gnt_o is forced 0 even if fetch_req_i=1.
  - Next cycle: the in-flight read still completes, fetch_rvalid_o=1 for it.
  - State becomes S_LOAD the cycle after load_start_i.
- load_start_i in S_LOAD restarts the load: new base, count=0. A word presented in the same cycle is not accepted.
- When no write or read is active, mem_addr_o holds its last value and mem_wen_o=0.
- Memory outputs are don't-care on write cycles, so fetch_rvalid_o is never asserted for a write cycle.
- Reset mid-load or mid-fetch: immediate return to S_IDLE with all outputs at reset values. Memory contents are not cleared.
- load_err_o stays set until the next load_start_i or reset.

Decomposition:
- Shared definitions package, already in use:
  - instruction_s typedef.
  - New state enum imem_ctrl_state_e {S_IDLE, S_LOAD, S_RUN}, so debug/trace logic can decode the state.
- No sub-module needed. The bench instantiates this block together with the existing instruction memory.

Test Plan:
- Reset then load_start_i with load_base_i=0; stream 4 words 0x11,0x22,0x33,0x44 (last on 4th), load_valid_i held high -> 4 consecutive mem_wen_o pulses at addr 0..3; state S_RUN and core_run_o=1 on the cycle after the 4th write.
- In S_RUN, fetch_req_i=1 with addresses 2,3,0 on consecutive cycles -> fetch_gnt_o=1 each cycle; fetch_rvalid_o=1 one cycle later each, fetch_instr_o=0x33,0x44,0x11.
- Wrap: addr_width_p=4, base=14, load 3 words A,B,C -> writes land at 14,15,0; fetching from 0 returns C.
- Overflow: addr_width_p=4, base=0, 17 valid words with no last -> 16 accepted, then load_ready_o=0; load_err_o=1, state S_IDLE, core_run_o=0.
- Reload during run: fetch granted at addr 1, load_start_i asserted the next cycle with fetch_req_i=1 -> that cycle fetch_gnt_o=0 and fetch_rvalid_o=1 (addr-1 data); core_run_o=0; S_LOAD the following cycle.
- Asynchronous reset mid-load after 2 of 5 words -> outputs at reset values immediately, before the next clk edge; a new load_start_i then succeeds normally.

Source files
------------

// File: rtl/imem_load_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory load/fetch controller:
// the instruction word layout and the controller state encoding.
package imem_load_fetch_ctrl_pkg;

   // 32-bit instruction word with the RISC-V style field breakdown.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instruction_s;

   // Boot flow states, exported so trace/debug logic can decode them.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } imem_ctrl_state_e;

endpackage

// File: rtl/imem_load_fetch_ctrl.sv
// Owns the single-port instruction memory and arbitrates its one port
// between the host program loader (writes) and the core fetch unit (reads).
// Boot flow: idle -> program load -> run; the core is gated by core_run_o.
module imem_load_fetch_ctrl
   import imem_load_fetch_ctrl_pkg::*;
#(
   parameter int unsigned addr_width_p = 10
) (
   input  logic                    clk,
   input  logic                    reset_n_i,
   // host program loader
   input  logic                    load_start_i,
   input  logic [addr_width_p-1:0] load_base_i,
   input  logic                    load_valid_i,
   input  instruction_s            load_instr_i,
   input  logic                    load_last_i,
   output logic                    load_ready_o,
   output logic                    load_err_o,
   // core fetch unit
   output logic                    core_run_o,
   input  logic                    fetch_req_i,
   input  logic [addr_width_p-1:0] fetch_addr_i,
   output logic                    fetch_gnt_o,
   output logic                    fetch_rvalid_o,
   output instruction_s            fetch_instr_o,
   // instruction memory port
   output logic [addr_width_p-1:0] mem_addr_o,
   output logic                    mem_wen_o,
   output instruction_s            mem_instr_o,
   input  instruction_s            mem_instr_i
);

   // Word count is one bit wider than the address so it can reach depth.
   localparam logic [addr_width_p:0] c_depth      = {1'b1, {addr_width_p{1'b0}}};
   localparam logic [addr_width_p:0] c_last_count = c_depth - 1'b1;

   imem_ctrl_state_e        r_state, w_state_next;
   logic [addr_width_p-1:0] r_wptr, w_wptr_next;
   logic [addr_width_p:0]   r_count, w_count_next;
   logic                    r_err, w_err_next;
   logic                    r_rvalid;
   logic [addr_width_p-1:0] r_mem_addr, w_mem_addr;
   logic                    w_load_ready;
   logic                    w_load_accept;
   logic                    w_run;
   logic                    w_fetch_gnt;

   // Next-state logic: boot sequencing, load pointer/count and error flag.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      w_state_next = r_state;
      w_wptr_next  = r_wptr;
      w_count_next = r_count;
      w_err_next   = r_err;
      w_load_ready = 1'b0;
      w_run        = 1'b0;

      if (load_start_i) begin
         // A start from any state (re)opens a load; nothing is accepted or
         // granted in the start cycle itself.
         w_state_next = S_LOAD;
         w_wptr_next  = load_base_i;
         w_count_next = '0;
         w_err_next   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_next = S_IDLE;
            end
            S_LOAD: begin
               w_load_ready = (r_count < c_depth);
               if (load_valid_i && w_load_ready) begin
                  // Pointer is address-wide, so it wraps past the top word.
                  w_wptr_next  = r_wptr + 1'b1;
                  w_count_next = r_count + 1'b1;
                  if (load_last_i) begin
                     w_state_next = S_RUN;
                  end else if (r_count == c_last_count) begin
                     // Memory is full and the loader still has not ended.
                     w_err_next   = 1'b1;
                     w_state_next = S_IDLE;
                  end
               end
            end
            S_RUN: begin
               w_run = 1'b1;
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   assign w_load_accept = load_valid_i & w_load_ready;
   assign w_fetch_gnt   = w_run & fetch_req_i;

   // Memory port mux: loader write, fetch read, or hold the last address.
   always_comb begin
      w_mem_addr = r_mem_addr;
      if (w_load_accept) begin
         w_mem_addr = r_wptr;
      end else if (w_fetch_gnt) begin
         w_mem_addr = fetch_addr_i;
      end
   end

   // Controller registers; rvalid trails the grant by exactly one cycle.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= S_IDLE;
         r_wptr     <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_rvalid   <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state    <= w_state_next;
         r_wptr     <= w_wptr_next;
         r_count    <= w_count_next;
         r_err      <= w_err_next;
         r_rvalid   <= w_fetch_gnt;
         r_mem_addr <= w_mem_addr;
      end
   end

   assign load_ready_o   = w_load_ready;
   assign load_err_o     = r_err;
   assign core_run_o     = w_run;
   assign fetch_gnt_o    = w_fetch_gnt;
   assign fetch_rvalid_o = r_rvalid;
   // Memory output is already registered, so it goes straight to fetch.
   assign fetch_instr_o  = mem_instr_i;
   assign mem_addr_o     = w_mem_addr;
   assign mem_wen_o      = w_load_accept;
   assign mem_instr_o    = load_instr_i;

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Self-checking bench: controller plus a behavioural synchronous memory,
// compared against a word-array model of what the loads put in memory.
module tb_imem_load_fetch_ctrl;
   import imem_load_fetch_ctrl_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          reset_n;
   logic          load_start;
   logic [AW-1:0] load_base;
   logic          load_valid;
   instruction_s  load_instr;
   logic          load_last;
   logic          load_ready;
   logic          load_err;
   logic          core_run;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_gnt;
   logic          fetch_rvalid;
   instruction_s  fetch_instr;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   instruction_s  mem_wdata;
   instruction_s  mem_rdata;

   int            n_checks;
   int            n_errors;

   logic [31:0]   tb_mem    [DEPTH];
   logic [31:0]   model_mem [DEPTH];
   logic [31:0]   stim      [32];
   int            fa        [8];

   imem_load_fetch_ctrl #(.addr_width_p(AW)) dut (
      .clk            (clk),
      .reset_n_i      (reset_n),
      .load_start_i   (load_start),
      .load_base_i    (load_base),
      .load_valid_i   (load_valid),
      .load_instr_i   (load_instr),
      .load_last_i    (load_last),
      .load_ready_o   (load_ready),
      .load_err_o     (load_err),
      .core_run_o     (core_run),
      .fetch_req_i    (fetch_req),
      .fetch_addr_i   (fetch_addr),
      .fetch_gnt_o    (fetch_gnt),
      .fetch_rvalid_o (fetch_rvalid),
      .fetch_instr_o  (fetch_instr),
      .mem_addr_o     (mem_addr),
      .mem_wen_o      (mem_wen),
      .mem_instr_o    (mem_wdata),
      .mem_instr_i    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous instruction memory with registered output.
   initial begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'd0;
   end
   always @(posedge clk) begin
      if (mem_wen) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Start a load at base, present n words from stim[], optionally ending with last.
   task automatic load_prog(input int base, input int n, input bit with_last);
      load_start = 1'b1;
      load_base  = AW'(base);
      load_valid = 1'b1;
      load_instr = stim[0];
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      settle();
      check("start_no_wen", 32'(mem_wen), 32'd0);
      check("start_no_ready", 32'(load_ready), 32'd0);
      tick();
      load_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         load_valid = 1'b1;
         load_instr = stim[k];
         load_last  = with_last && (k == n - 1);
         settle();
         if (k == 0) check("err_cleared", 32'(load_err), 32'd0);
         if (k < DEPTH) begin
            check("load_ready", 32'(load_ready), 32'd1);
            check("load_wen", 32'(mem_wen), 32'd1);
            check("load_addr", 32'(mem_addr), 32'((base + k) % DEPTH));
            check("load_data", 32'(mem_wdata), stim[k]);
            check("load_no_run", 32'(core_run), 32'd0);
            model_mem[(base + k) % DEPTH] = stim[k];
         end else begin
            check("ovf_ready", 32'(load_ready), 32'd0);
            check("ovf_wen", 32'(mem_wen), 32'd0);
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      settle();
      if (with_last) begin
         check("run_after_last", 32'(core_run), 32'd1);
         check("state_run", 32'(dut.r_state), 32'(S_RUN));
         check("no_err", 32'(load_err), 32'd0);
      end else if (n >= DEPTH) begin
         check("ovf_err", 32'(load_err), 32'd1);
         check("ovf_state", 32'(dut.r_state), 32'(S_IDLE));
         check("ovf_run", 32'(core_run), 32'd0);
         check("ovf_ready_idle", 32'(load_ready), 32'd0);
      end
      tick();
   endtask

   // Back-to-back fetches from fa[0..n-1]; data checked one cycle later.
   task automatic fetch_seq(input int n);
      for (int i = 0; i < n; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = AW'(fa[i]);
         settle();
         check("fetch_gnt", 32'(fetch_gnt), 32'd1);
         check("fetch_addr", 32'(mem_addr), 32'(fa[i]));
         check("fetch_no_wen", 32'(mem_wen), 32'd0);
         if (i > 0) begin
            check("fetch_rvalid", 32'(fetch_rvalid), 32'd1);
            check("fetch_data", 32'(fetch_instr), model_mem[fa[i-1]]);
         end
         tick();
      end
      fetch_req = 1'b0;
      settle();
      check("fetch_rvalid_last", 32'(fetch_rvalid), 32'd1);
      check("fetch_data_last", 32'(fetch_instr), model_mem[fa[n-1]]);
      check("idle_gnt", 32'(fetch_gnt), 32'd0);
      check("addr_hold", 32'(mem_addr), 32'(fa[n-1]));
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(load_ready), 32'd0);
      check({tag, "_err"}, 32'(load_err), 32'd0);
      check({tag, "_run"}, 32'(core_run), 32'd0);
      check({tag, "_gnt"}, 32'(fetch_gnt), 32'd0);
      check({tag, "_rvalid"}, 32'(fetch_rvalid), 32'd0);
      check({tag, "_wen"}, 32'(mem_wen), 32'd0);
      check({tag, "_state"}, 32'(dut.r_state), 32'(S_IDLE));
   endtask

   initial begin
      bit prev_gnt;
      int prev_addr;
      int base;
      int n;

      n_checks   = 0;
      n_errors   = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      reset_n    = 1'b0;
      load_start = 1'b0;
      load_base  = '0;
      load_valid = 1'b0;
      load_instr = '0;
      load_last  = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = '0;

      // Reset state, and nothing granted in idle even with a fetch request.
      #12;
      check_reset_outputs("rst");
      tick();
      reset_n = 1'b1;
      settle();
      check_reset_outputs("idle");
      tick();

      // Basic load of four words at base 0, then fetch 2,3,0.
      stim[0] = 32'h11; stim[1] = 32'h22; stim[2] = 32'h33; stim[3] = 32'h44;
      load_prog(0, 4, 1'b1);
      fa[0] = 2; fa[1] = 3; fa[2] = 0;
      fetch_seq(3);

      // Reload during run: grant at addr 1, then start with a request pending.
      fetch_req  = 1'b1;
      fetch_addr = AW'(1);
      settle();
      check("pre_reload_gnt", 32'(fetch_gnt), 32'd1);
      tick();
      load_start = 1'b1;
      load_base  = AW'(8);
      load_valid = 1'b1;
      load_instr = 32'hdead;
      fetch_addr = AW'(2);
      settle();
      check("reload_gnt", 32'(fetch_gnt), 32'd0);
      check("reload_run", 32'(core_run), 32'd0);
      check("reload_rvalid", 32'(fetch_rvalid), 32'd1);
      check("reload_data", 32'(fetch_instr), model_mem[1]);
      check("reload_wen", 32'(mem_wen), 32'd0);
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      fetch_req  = 1'b0;
      settle();
      check("reload_state", 32'(dut.r_state), 32'(S_LOAD));
      check("reload_rvalid_drop", 32'(fetch_rvalid), 32'd0);
      check("reload_ready", 32'(load_ready), 32'd1);
      tick();

      // Wrap: base 14, three words land at 14, 15, 0 (restarts the open load).
      stim[0] = 32'hA; stim[1] = 32'hB; stim[2] = 32'hC;
      load_prog(14, 3, 1'b1);
      fa[0] = 0; fa[1] = 14; fa[2] = 15;
      fetch_seq(3);

      // Overflow: 17 words with no last, only 16 accepted.
      for (int i = 0; i < 17; i++) stim[i] = 32'h100 + 32'(i);
      load_prog(0, 17, 1'b0);

      // Asynchronous reset mid-load after 2 of 5 words.
      for (int i = 0; i < 5; i++) stim[i] = 32'h500 + 32'(i);
      load_start = 1'b1;
      load_base  = AW'(5);
      tick();
      load_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         load_valid = 1'b1;
         load_instr = stim[k];
         settle();
         check("prerst_wen", 32'(mem_wen), 32'd1);
         model_mem[5 + k] = stim[k];
         tick();
      end
      load_instr = stim[2];
      settle();
      check("prerst_err_clear", 32'(load_err), 32'd0);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      tick();
      reset_n    = 1'b1;
      load_valid = 1'b0;
      tick();
      load_prog(3, 5, 1'b1);
      fa[0] = 3; fa[1] = 7; fa[2] = 5; fa[3] = 6; fa[4] = 4;
      fetch_seq(5);

      // Randomized loads followed by random fetch traffic.
      for (int it = 0; it < 6; it++) begin
         base = int'($urandom_range(0, DEPTH - 1));
         n    = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) stim[i] = $urandom;
         load_prog(base, n, 1'b1);
         prev_gnt  = 1'b0;
         prev_addr = 0;
         for (int c = 0; c < 12; c++) begin
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = AW'($urandom_range(0, DEPTH - 1));
            settle();
            check("rnd_gnt", 32'(fetch_gnt), 32'(fetch_req));
            check("rnd_rvalid", 32'(fetch_rvalid), 32'(prev_gnt));
            if (prev_gnt) check("rnd_data", 32'(fetch_instr), model_mem[prev_addr]);
            if (fetch_req) check("rnd_addr", 32'(mem_addr), 32'(fetch_addr));
            prev_gnt  = fetch_req;
            prev_addr = int'(fetch_addr);
            tick();
         end
         fetch_req = 1'b0;
         settle();
         check("rnd_rvalid_tail", 32'(fetch_rvalid), 32'(prev_gnt));
         if (prev_gnt) check("rnd_data_tail", 32'(fetch_instr), model_mem[prev_addr]);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
